// File: rtl/spart_rx.sv
// spart_rx: SPART receive path. Oversamples RxD at 16 ticks per bit (8N1,
// LSB first), assembles a byte and exposes it to the processor bus with
// receive-data-available, framing-error and overrun status.
module spart_rx (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       rxd,
   input  logic       iocs,
   input  logic       iorw,
   input  logic [1:0] ioaddr,
   output logic [7:0] rx_data,
   output logic       rda,
   output logic       framing_err,
   output logic       overrun
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_STOP      = 3'd3,
      S_WAIT_HIGH = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_next_state;

   logic        r_rxd_meta;
   logic        r_rxs;
   logic [3:0]  r_tick;
   logic [2:0]  r_bit;
   logic [7:0]  r_shift;
   logic [7:0]  r_rx_data;
   logic        r_rda;
   logic        r_framing_err;
   logic        r_overrun;

   logic        w_mid_tick;
   logic        w_end_tick;
   logic        w_start_ok;
   logic        w_shift;
   logic        w_done;
   logic        w_tick_clr;
   logic        w_read;

   // Two-flop synchronizer; both stages idle high so reset never looks like a start bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rxd_meta <= 1'b1;
         r_rxs      <= 1'b1;
      end else begin
         r_rxd_meta <= rxd;
         r_rxs      <= r_rxd_meta;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   // Next-state logic: start detect is per clock, all later sampling is per en tick
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:      if (!r_rxs) w_next_state = S_START;
         S_START:     if (w_mid_tick) w_next_state = r_rxs ? S_IDLE : S_DATA;
         S_DATA:      if (w_end_tick && (r_bit == 3'd7)) w_next_state = S_STOP;
         S_STOP:      if (w_end_tick) w_next_state = r_rxs ? S_IDLE : S_WAIT_HIGH;
         S_WAIT_HIGH: if (r_rxs) w_next_state = S_IDLE;
         default:     w_next_state = S_IDLE;
      endcase
   end

   // Output/control decode for the datapath and the bus-side status registers
   always_comb begin
      w_mid_tick = en && (r_tick == 4'd7);
      w_end_tick = en && (r_tick == 4'd15);
      w_start_ok = (r_state == S_START) && w_mid_tick && !r_rxs;
      w_shift    = (r_state == S_DATA) && w_end_tick;
      w_done     = (r_state == S_STOP) && w_end_tick;
      // Counter is held at zero whenever no frame is in progress, and re-aligned
      // to the middle of the start bit so data samples land mid-bit
      w_tick_clr = (r_state == S_IDLE) || (r_state == S_WAIT_HIGH) ||
                   ((r_state == S_START) && w_mid_tick);
      w_read     = iocs && iorw && (ioaddr == 2'b00);
   end

   // Tick counter, bit counter and LSB-first shift register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tick  <= 4'd0;
         r_bit   <= 3'd0;
         r_shift <= 8'h00;
      end else begin
         if (w_tick_clr)  r_tick <= 4'd0;
         else if (en)     r_tick <= r_tick + 4'd1;

         if (w_start_ok)  r_bit <= 3'd0;
         else if (w_shift) r_bit <= r_bit + 3'd1;

         if (w_shift)     r_shift <= {r_rxs, r_shift[7:1]};
      end
   end

   // Bus-visible status: completion takes priority over a coincident read
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_data     <= 8'h00;
         r_rda         <= 1'b0;
         r_framing_err <= 1'b0;
         r_overrun     <= 1'b0;
      end else if (w_done) begin
         r_rx_data     <= r_shift;
         r_rda         <= 1'b1;
         r_framing_err <= ~r_rxs;
         if (r_rda) r_overrun <= 1'b1;
      end else if (w_read) begin
         r_rda     <= 1'b0;
         r_overrun <= 1'b0;
      end
   end

   assign rx_data     = r_rx_data;
   assign rda         = r_rda;
   assign framing_err = r_framing_err;
   assign overrun     = r_overrun;

endmodule

// File: doc/spart_rx.md
# spart_rx

SPART receive path: consumes the 16x-oversample enable pulse from the baud generator, synchronizes and samples the serial RxD line (8N1, LSB first), assembles a byte, and presents it to the processor bus with a Receive-Data-Available flag. It sits beside the baud generator and transmitter inside the SPART, on the same bus-side I/O decode.

## Interface
Parameters: none (frame fixed at 1 start, 8 data, 1 stop, 16 ticks per bit).

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  oversample tick from the baud generator; one-cycle pulse, 16 per bit time.
- rxd  in  1  asynchronous serial input; idle high.
- iocs  in  1  SPART chip select.
- iorw  in  1  1 = bus read, 0 = bus write.
- ioaddr  in  2  register select; 2'b00 = receive buffer.
- rx_data  out  8  last received byte; held until the next byte completes.
- rda  out  1  receive data available.
- framing_err  out  1  stop bit of the last completed byte sampled low.
- overrun  out  1  a byte completed while rda was still set.

## Operation
- rxd passes through a 2-flop synchronizer (both flops reset to 1); all logic uses the synchronized value rxs.
- 4-bit tick counter advances only on cycles with en=1; 3-bit bit counter; 8-bit shift register shifting right, new bit in at [7].
- FSM states:
  - IDLE: on rxs==0 -> START, tick counter cleared.
  - START: on the 8th en tick (mid start bit), sample rxs: 0 -> DATA with tick and bit counters cleared; 1 -> IDLE (false start / glitch).
  - DATA: on every 16th en tick, shift rxs in; after the 8th bit -> STOP, tick counter cleared.
  - STOP: on the 16th en tick, sample rxs. Load rx_data from shift register, set rda, set framing_err = ~rxs. rxs==1 -> IDLE; rxs==0 -> WAIT_HIGH.
  - WAIT_HIGH: stay until rxs==1, then IDLE (prevents a break condition from retriggering).
- Bus read of receive buffer: iocs & iorw & ioaddr==2'b00 in a cycle clears rda and overrun on the next edge. rx_data is not altered by the read.
- Writes and other addresses have no effect on this block.
- Byte completion while rda==1: rx_data overwritten, overrun set.
- Completion and read in the same cycle: completion wins; rda stays 1, rx_data takes the new byte; overrun is set (old byte was unread at that edge).
- en ignored outside a frame except that IDLE does not depend on it (start detection is per clock).

## Timing
- Reset values: rx_data=8'h00, rda=0, framing_err=0, overrun=0, FSM=IDLE, counters=0, shift register=0.
- rxd falling edge reaches rxs after 2 clk edges.
- Start sample at 8th en tick after START entry; each data bit sampled 16 ticks after the previous sample; stop sampled 16 ticks after bit 7.
- rda, rx_data, framing_err update on the clock edge of the stop-sample en tick (registered; visible the following cycle).
- rda clears on the edge after the read cycle.
- rst_n low mid-frame: immediate return to all reset values; partial byte discarded; after release, reception restarts only from a new start edge.
- en asserted on consecutive cycles is legal; each en-high cycle counts one tick.

## Test plan
- Baud generator at divisor 3 (en every 4 clk), send 0xA5 with stop=1 -> after stop sample rx_data=8'hA5, rda=1, framing_err=0, overrun=0.
- rxd low for 3 en ticks then high -> FSM returns to IDLE, rda stays 0, rx_data unchanged.
- Send 0x3C with stop bit 0, hold rxd low 40 ticks, then high -> rx_data=8'h3C, rda=1, framing_err=1; no second byte reported until rxd returns high and a new start arrives.
- Receive 0x11, read (iocs=1, iorw=1, ioaddr=00) -> rda=0 next cycle; receive 0x22 without reading, then 0x33 -> rx_data=8'h33, overrun=1; read clears rda and overrun.
- Read asserted on the exact completion cycle of 0x44 -> rda remains 1, rx_data=8'h44.
- Assert rst_n low during data bit 4 of 0x5A -> all outputs 0; send 0x81 after release -> rx_data=8'h81, rda=1, no corruption from aborted frame.
